write_data_buffer: RTL and testbench
====================================

Name: write_data_buffer

Overview:
- Parametrised multi-burst write-data buffer for the DDR controller datapath; successor to the single-burst write data register.
- Accepts host write beats (data plus byte strobes) on a valid/ready interface and packs them into complete bursts of BURST_LEN beats.
- Holds up to DEPTH bursts in FIFO order.
- On each write-launch pulse from the command scheduler, streams one burst onto the DQ/DM output path on consecutive cycles, with gapless back-to-back support.

Parameters:
- DQ_WIDTH, 16, data beat width in bits; must be a multiple of 8.
- BURST_LEN, 8, beats per burst; power of 2, at least 2.
- DEPTH, 4, number of burst slots; power of 2, at least 2.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- wd_valid  in  1  host beat valid.
- wd_ready  out  1  buffer can accept a beat.
- wd_data  in  DQ_WIDTH  host beat data.
- wd_strb  in  DQ_WIDTH/8  byte enables; 1 = write this byte.
- burst_avail  out  1  at least one complete burst stored.
- burst_count  out  $clog2(DEPTH+1)  number of complete bursts stored.
- wr_start  in  1  single-cycle pulse that launches one burst.
- dq_out  out  DQ_WIDTH  beat data to PHY.
- dm_out  out  DQ_WIDTH/8  data mask to PHY; 1 = masked. Equals ~wd_strb of the beat.
- dq_oe  out  1  beat valid / output enable.
- underrun_err  out  1  sticky: wr_start arrived with no burst available.
- overlap_err  out  1  sticky: wr_start arrived mid-burst, other than on the final beat.
- err_clr  in  1  clears both sticky errors.

Behaviour:
- Reset values: wd_ready 0 in the reset cycle, then 1; burst_avail 0; burst_count 0; dq_out 0; dm_out all 1s; dq_oe 0; both errors 0. Pointers, beat counters and FSM all cleared. Storage contents are don't-care.
- Fill side:
  - Handshake occurs when wd_valid && wd_ready.
  - Beat is written at slot wr_ptr, index fill_beat; fill_beat increments.
  - When fill_beat == BURST_LEN-1 on a handshake, the burst commits: burst_count +1 and wr_ptr +1 (mod DEPTH) on that edge, fill_beat wraps to 0.
- wd_ready = (burst_count < DEPTH). A partially filled slot is always free. When full, wd_ready is 0 and wd_valid is ignored.
- burst_avail = (burst_count != 0), taken from the registered count.
- Drain FSM has two states, IDLE and DRAIN.
  - IDLE, wr_start && burst_avail: go to DRAIN, drain_beat = 0. Beat 0 appears on dq_out/dm_out with dq_oe = 1 in the following cycle (1-cycle latency, registered outputs).
  - DRAIN: one beat per cycle from slot rd_ptr.
  - On the cycle presenting beat BURST_LEN-1: burst_count -1 and rd_ptr +1 at the closing edge.
  - If wr_start is also high on that cycle and another burst is available (count > 1, or a commit in that same cycle), stay in DRAIN and present the next burst's beat 0 on the next cycle (gapless). Otherwise return to IDLE.
- Idle outputs: dq_oe 0, dq_out 0, dm_out all 1s.
- Commit and release in the same cycle: burst_count unchanged.
- Error rules:
  - wr_start with burst_avail = 0 (including the cycle a first commit happens): ignored, underrun_err set.
  - wr_start in DRAIN not on the final beat: ignored, overlap_err set.
  - err_clr has priority over setting in the same cycle.
- Reset mid-operation: on the reset edge dq_oe drops, the partial fill is discarded and all bursts are lost.
- Pointer wrap: rd_ptr and wr_ptr wrap mod DEPTH. Full/empty are decided only by burst_count.

Decomposition:
- Shared ddr_pkg holds:
  - DM width function (DQ_WIDTH/8);
  - drain FSM enum (WDB_IDLE, WDB_DRAIN);
  - idle constants DQ_IDLE = 0 and DM_IDLE = all 1s.
- One sub-module, wdb_storage: simple dual-port register array of DEPTH*BURST_LEN entries, each {strb, data}. Write port indexed {wr_ptr, fill_beat}; combinational read indexed {rd_ptr, drain_beat}. Output registers stay in the parent.

Test Plan:
- Reset then idle: assert rst 2 cycles → wd_ready 1, burst_count 0, dq_oe 0, dm_out 2'b11 with defaults.
- Single burst: push beats 16'h1000..16'h1007, strb 2'b11, then wr_start → burst_count goes 0→1 on 8th handshake. dq_oe is high 8 cycles starting 1 cycle after wr_start; dq_out = 1000..1007, dm_out 00; burst_count back to 0.
- Full/backpressure: push 4 bursts (32 beats) with wd_valid held → wd_ready falls after 32nd handshake. Beat 33 is held until the first drain's final beat, then wd_ready rises.
- Gapless back-to-back: 2 bursts stored (A0..A7, B0..B7); wr_start, then wr_start again on the A7 cycle → 16 consecutive dq_oe cycles, A7 immediately followed by B0, burst_count 2→1→0.
- Masking: beat 3 strb 2'b01 → dm_out 2'b10 on the 4th drained beat only.
- Errors: wr_start while empty → underrun_err 1 and dq_oe stays 0. wr_start on drain beat 2 → overlap_err 1, burst length unaffected. err_clr → both errors 0. rst asserted on drain beat 4 → dq_oe 0 next cycle, burst_count 0.

Source files
------------

// File: rtl/ddr_pkg.sv
// Shared types and constants for the DDR controller write datapath.
package ddr_pkg;

  localparam int MAX_DQ_WIDTH = 1024;

  // Idle levels for the PHY data path; slice to the instance width.
  localparam logic [MAX_DQ_WIDTH-1:0]   DQ_IDLE = '0;
  localparam logic [MAX_DQ_WIDTH/8-1:0] DM_IDLE = '1;

  typedef enum logic {
    WDB_IDLE  = 1'b0,
    WDB_DRAIN = 1'b1
  } wdb_state_e;

  function automatic int dm_width(input int dq_width);
    return dq_width / 8;
  endfunction

endpackage

// File: rtl/wdb_storage.sv
// Simple dual-port beat store: one synchronous write port, one combinational read port.
module wdb_storage #(
  parameter int ENTRY_W   = 18,
  parameter int DEPTH     = 4,
  parameter int BURST_LEN = 8
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [$clog2(DEPTH)-1:0]     wr_slot,
  input  logic [$clog2(BURST_LEN)-1:0] wr_beat,
  input  logic [ENTRY_W-1:0]           wr_entry,
  input  logic [$clog2(DEPTH)-1:0]     rd_slot,
  input  logic [$clog2(BURST_LEN)-1:0] rd_beat,
  output logic [ENTRY_W-1:0]           rd_entry
);

  localparam int ENTRIES = DEPTH * BURST_LEN;

  logic [ENTRY_W-1:0] mem [ENTRIES];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[{wr_slot, wr_beat}] <= wr_entry;
    end
  end

  assign rd_entry = mem[{rd_slot, rd_beat}];

endmodule

// File: rtl/write_data_buffer.sv
// Multi-burst write-data buffer: packs host beats into bursts and streams one
// burst per write-launch pulse onto the DQ/DM path, gapless when back-to-back.
module write_data_buffer
  import ddr_pkg::*;
#(
  parameter int DQ_WIDTH  = 16,
  parameter int BURST_LEN = 8,
  parameter int DEPTH     = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             wd_valid,
  output logic                             wd_ready,
  input  logic [DQ_WIDTH-1:0]              wd_data,
  input  logic [dm_width(DQ_WIDTH)-1:0]    wd_strb,
  output logic                             burst_avail,
  output logic [$clog2(DEPTH+1)-1:0]       burst_count,
  input  logic                             wr_start,
  output logic [DQ_WIDTH-1:0]              dq_out,
  output logic [dm_width(DQ_WIDTH)-1:0]    dm_out,
  output logic                             dq_oe,
  output logic                             underrun_err,
  output logic                             overlap_err,
  input  logic                             err_clr
);

  localparam int DMW = dm_width(DQ_WIDTH);
  localparam int PW  = $clog2(DEPTH);
  localparam int BW  = $clog2(BURST_LEN);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int EW  = DMW + DQ_WIDTH;

  wdb_state_e    state;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] rd_sel_ptr;
  logic [BW-1:0] fill_beat;
  logic [BW-1:0] drain_beat;
  logic [BW-1:0] rd_sel_beat;
  logic [EW-1:0] rd_entry;
  logic          handshake;
  logic          commit;
  logic          last_beat;
  logic          more_avail;
  logic          launch;
  logic          chain;
  logic          underrun_set;
  logic          overlap_set;

  assign wd_ready    = !rst && (burst_count < CW'(DEPTH));
  assign burst_avail = (burst_count != '0);
  assign handshake   = wd_valid && wd_ready;
  assign commit      = handshake && (fill_beat == BW'(BURST_LEN - 1));
  assign last_beat   = (state == WDB_DRAIN) && (drain_beat == BW'(BURST_LEN - 1));
  assign more_avail  = (burst_count > CW'(1)) || commit;
  assign launch      = (state == WDB_IDLE) && wr_start && burst_avail;
  assign chain       = last_beat && wr_start && more_avail;

  // Read address looks one beat ahead so the output register holds the beat
  // being presented; on the final beat it points at the next slot's beat 0.
  assign rd_sel_ptr  = last_beat ? rd_ptr + PW'(1) : rd_ptr;
  assign rd_sel_beat = ((state == WDB_DRAIN) && !last_beat) ? drain_beat + BW'(1) : '0;

  assign underrun_set = wr_start && (((state == WDB_IDLE) && !burst_avail) ||
                                     (last_beat && !more_avail));
  assign overlap_set  = wr_start && (state == WDB_DRAIN) && !last_beat;

  wdb_storage #(
    .ENTRY_W   (EW),
    .DEPTH     (DEPTH),
    .BURST_LEN (BURST_LEN)
  ) u_storage (
    .clk      (clk),
    .we       (handshake),
    .wr_slot  (wr_ptr),
    .wr_beat  (fill_beat),
    .wr_entry ({wd_strb, wd_data}),
    .rd_slot  (rd_sel_ptr),
    .rd_beat  (rd_sel_beat),
    .rd_entry (rd_entry)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      fill_beat <= '0;
    end else if (handshake) begin
      fill_beat <= commit ? '0 : fill_beat + BW'(1);
      if (commit) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      burst_count <= '0;
    end else begin
      case ({commit, last_beat})
        2'b10:   burst_count <= burst_count + CW'(1);
        2'b01:   burst_count <= burst_count - CW'(1);
        default: burst_count <= burst_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= WDB_IDLE;
      rd_ptr     <= '0;
      drain_beat <= '0;
      dq_out     <= DQ_IDLE[DQ_WIDTH-1:0];
      dm_out     <= DM_IDLE[DMW-1:0];
      dq_oe      <= 1'b0;
    end else begin
      case (state)
        WDB_IDLE: begin
          if (launch) begin
            state      <= WDB_DRAIN;
            drain_beat <= '0;
            dq_out     <= rd_entry[DQ_WIDTH-1:0];
            dm_out     <= ~rd_entry[EW-1:DQ_WIDTH];
            dq_oe      <= 1'b1;
          end
        end
        WDB_DRAIN: begin
          if (!last_beat) begin
            drain_beat <= drain_beat + BW'(1);
            dq_out     <= rd_entry[DQ_WIDTH-1:0];
            dm_out     <= ~rd_entry[EW-1:DQ_WIDTH];
            dq_oe      <= 1'b1;
          end else begin
            rd_ptr <= rd_ptr + PW'(1);
            if (chain) begin
              drain_beat <= '0;
              dq_out     <= rd_entry[DQ_WIDTH-1:0];
              dm_out     <= ~rd_entry[EW-1:DQ_WIDTH];
              dq_oe      <= 1'b1;
            end else begin
              state      <= WDB_IDLE;
              drain_beat <= '0;
              dq_out     <= DQ_IDLE[DQ_WIDTH-1:0];
              dm_out     <= DM_IDLE[DMW-1:0];
              dq_oe      <= 1'b0;
            end
          end
        end
      endcase
    end
  end

  // Clear wins over a simultaneous set so software never loses a clear.
  always_ff @(posedge clk) begin
    if (rst || err_clr) begin
      underrun_err <= 1'b0;
      overlap_err  <= 1'b0;
    end else begin
      if (underrun_set) underrun_err <= 1'b1;
      if (overlap_set)  overlap_err  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_write_data_buffer.sv
// Directed, table-driven bench for write_data_buffer with hand-computed expectations.
module tb_write_data_buffer;

  localparam int DQ_WIDTH  = 16;
  localparam int BURST_LEN = 8;
  localparam int DEPTH     = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        wd_valid;
  logic        wd_ready;
  logic [15:0] wd_data;
  logic [1:0]  wd_strb;
  logic        burst_avail;
  logic [2:0]  burst_count;
  logic        wr_start;
  logic [15:0] dq_out;
  logic [1:0]  dm_out;
  logic        dq_oe;
  logic        underrun_err;
  logic        overlap_err;
  logic        err_clr;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic        valid;
    logic [15:0] data;
    logic [1:0]  strb;
    logic        start;
    logic        clr;
    logic        exp_oe;
    logic [15:0] exp_dq;
    logic [1:0]  exp_dm;
    logic [2:0]  exp_count;
    logic        exp_ready;
  } vec_t;

  vec_t vecs[17];

  always #5 clk = ~clk;

  write_data_buffer #(
    .DQ_WIDTH  (DQ_WIDTH),
    .BURST_LEN (BURST_LEN),
    .DEPTH     (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wd_valid     (wd_valid),
    .wd_ready     (wd_ready),
    .wd_data      (wd_data),
    .wd_strb      (wd_strb),
    .burst_avail  (burst_avail),
    .burst_count  (burst_count),
    .wr_start     (wr_start),
    .dq_out       (dq_out),
    .dm_out       (dm_out),
    .dq_oe        (dq_oe),
    .underrun_err (underrun_err),
    .overlap_err  (overlap_err),
    .err_clr      (err_clr)
  );

  task automatic applyStimulus(input logic v, input logic [15:0] d, input logic [1:0] s,
                               input logic st, input logic clr);
    wd_valid = v;
    wd_data  = d;
    wd_strb  = s;
    wr_start = st;
    err_clr  = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic pushBurst(input logic [15:0] base);
    logic [15:0] d;
    for (int i = 0; i < BURST_LEN; i++) begin
      d = base + 16'(i);
      applyStimulus(1'b1, d, 2'b11, 1'b0, 1'b0);
    end
    wd_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] d;
    logic [15:0] exp_d;
    logic        st;

    rst = 1'b1;
    wd_valid = 1'b0; wd_data = '0; wd_strb = 2'b11; wr_start = 1'b0; err_clr = 1'b0;

    // Reset: two cycles, wd_ready held low while reset is high.
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("ready_in_reset", 32'(wd_ready), 0);
    rst = 1'b0;
    #1;
    checkOutput("reset_ready", 32'(wd_ready), 1);
    checkOutput("reset_count", 32'(burst_count), 0);
    checkOutput("reset_avail", 32'(burst_avail), 0);
    checkOutput("reset_oe", 32'(dq_oe), 0);
    checkOutput("reset_dq", 32'(dq_out), 0);
    checkOutput("reset_dm", 32'(dm_out), 32'h3);
    checkOutput("reset_underrun", 32'(underrun_err), 0);
    checkOutput("reset_overlap", 32'(overlap_err), 0);

    // Single burst with beat 3 partially masked, then drained.
    for (int i = 0; i < 8; i++) begin
      d = 16'h1000 + 16'(i);
      vecs[i] = '{1'b1, d, (i == 3) ? 2'b01 : 2'b11, 1'b0, 1'b0,
                  1'b0, 16'h0000, 2'b11, (i == 7) ? 3'd1 : 3'd0, 1'b1};
    end
    vecs[8] = '{1'b0, 16'h0000, 2'b11, 1'b1, 1'b0, 1'b1, 16'h1000, 2'b00, 3'd1, 1'b1};
    for (int i = 9; i < 16; i++) begin
      d = 16'h1000 + 16'(i - 8);
      vecs[i] = '{1'b0, 16'h0000, 2'b11, 1'b0, 1'b0,
                  1'b1, d, (i == 11) ? 2'b10 : 2'b00, 3'd1, 1'b1};
    end
    vecs[16] = '{1'b0, 16'h0000, 2'b11, 1'b0, 1'b0, 1'b0, 16'h0000, 2'b11, 3'd0, 1'b1};

    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i].valid, vecs[i].data, vecs[i].strb, vecs[i].start, vecs[i].clr);
      checkOutput($sformatf("vec%0d_oe", i), 32'(dq_oe), 32'(vecs[i].exp_oe));
      checkOutput($sformatf("vec%0d_dq", i), 32'(dq_out), 32'(vecs[i].exp_dq));
      checkOutput($sformatf("vec%0d_dm", i), 32'(dm_out), 32'(vecs[i].exp_dm));
      checkOutput($sformatf("vec%0d_count", i), 32'(burst_count), 32'(vecs[i].exp_count));
      checkOutput($sformatf("vec%0d_ready", i), 32'(wd_ready), 32'(vecs[i].exp_ready));
    end

    // Gapless: wr_start again on the cycle presenting A7.
    pushBurst(16'h2000);
    pushBurst(16'h3000);
    checkOutput("gapless_count_start", 32'(burst_count), 2);
    for (int e = 0; e <= 16; e++) begin
      st = (e == 0) || (e == 8);
      applyStimulus(1'b0, 16'h0000, 2'b11, st, 1'b0);
      if (e < 16) begin
        exp_d = (e < 8) ? 16'h2000 + 16'(e) : 16'h3000 + 16'(e - 8);
        checkOutput($sformatf("gapless%0d_oe", e), 32'(dq_oe), 1);
        checkOutput($sformatf("gapless%0d_dq", e), 32'(dq_out), 32'(exp_d));
        checkOutput($sformatf("gapless%0d_count", e), 32'(burst_count), (e < 8) ? 2 : 1);
      end else begin
        checkOutput("gapless_end_oe", 32'(dq_oe), 0);
        checkOutput("gapless_end_count", 32'(burst_count), 0);
      end
    end
    checkOutput("gapless_overlap", 32'(overlap_err), 0);
    checkOutput("gapless_underrun", 32'(underrun_err), 0);

    // Underrun while empty, then clear beating a simultaneous set.
    applyStimulus(1'b0, 16'h0000, 2'b11, 1'b1, 1'b0);
    checkOutput("underrun_set", 32'(underrun_err), 1);
    checkOutput("underrun_oe", 32'(dq_oe), 0);
    applyStimulus(1'b0, 16'h0000, 2'b11, 1'b0, 1'b0);
    checkOutput("underrun_oe_stays", 32'(dq_oe), 0);
    checkOutput("underrun_sticky", 32'(underrun_err), 1);
    applyStimulus(1'b0, 16'h0000, 2'b11, 1'b1, 1'b1);
    checkOutput("clr_priority", 32'(underrun_err), 0);

    // Underrun on the cycle of the first commit: burst is stored, no launch.
    for (int i = 0; i < 7; i++) begin
      d = 16'h7000 + 16'(i);
      applyStimulus(1'b1, d, 2'b11, 1'b0, 1'b0);
    end
    applyStimulus(1'b1, 16'h7007, 2'b11, 1'b1, 1'b0);
    checkOutput("commit_underrun_err", 32'(underrun_err), 1);
    checkOutput("commit_underrun_count", 32'(burst_count), 1);
    checkOutput("commit_underrun_oe", 32'(dq_oe), 0);
    applyStimulus(1'b0, 16'h0000, 2'b11, 1'b0, 1'b1);
    checkOutput("commit_underrun_no_launch", 32'(dq_oe), 0);
    checkOutput("commit_underrun_clr", 32'(underrun_err), 0);

    // Overlap: wr_start on drain beat 2 must not disturb the burst.
    for (int e = 0; e <= 8; e++) begin
      st = (e == 0) || (e == 3);
      applyStimulus(1'b0, 16'h0000, 2'b11, st, 1'b0);
      if (e < 8) begin
        exp_d = 16'h7000 + 16'(e);
        checkOutput($sformatf("overlap%0d_oe", e), 32'(dq_oe), 1);
        checkOutput($sformatf("overlap%0d_dq", e), 32'(dq_out), 32'(exp_d));
      end else begin
        checkOutput("overlap_end_oe", 32'(dq_oe), 0);
        checkOutput("overlap_end_count", 32'(burst_count), 0);
      end
      if (e == 2) checkOutput("overlap_before", 32'(overlap_err), 0);
      if (e == 3) checkOutput("overlap_set", 32'(overlap_err), 1);
    end
    checkOutput("overlap_no_underrun", 32'(underrun_err), 0);
    applyStimulus(1'b0, 16'h0000, 2'b11, 1'b0, 1'b1);
    checkOutput("overlap_clr", 32'(overlap_err), 0);

    // Fill all four slots; beat 33 waits until the first drain releases.
    for (int i = 0; i < 32; i++) begin
      d = 16'h4000 + 16'(i);
      applyStimulus(1'b1, d, 2'b11, 1'b0, 1'b0);
    end
    checkOutput("full_count", 32'(burst_count), 4);
    checkOutput("full_ready", 32'(wd_ready), 0);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 16'h5000, 2'b11, 1'b0, 1'b0);
      checkOutput($sformatf("full_hold%0d_ready", i), 32'(wd_ready), 0);
      checkOutput($sformatf("full_hold%0d_count", i), 32'(burst_count), 4);
    end
    for (int e = 0; e <= 8; e++) begin
      applyStimulus(1'b1, 16'h5000, 2'b11, (e == 0), 1'b0);
      if (e < 8) begin
        exp_d = 16'h4000 + 16'(e);
        checkOutput($sformatf("full_drain%0d_dq", e), 32'(dq_out), 32'(exp_d));
        checkOutput($sformatf("full_drain%0d_ready", e), 32'(wd_ready), 0);
        checkOutput($sformatf("full_drain%0d_count", e), 32'(burst_count), 4);
      end else begin
        checkOutput("full_release_count", 32'(burst_count), 3);
        checkOutput("full_release_ready", 32'(wd_ready), 1);
      end
    end
    applyStimulus(1'b1, 16'h5000, 2'b11, 1'b0, 1'b0);
    for (int i = 1; i < 8; i++) begin
      d = 16'h5000 + 16'(i);
      applyStimulus(1'b1, d, 2'b11, 1'b0, 1'b0);
    end
    wd_valid = 1'b0;
    checkOutput("refill_count", 32'(burst_count), 4);
    checkOutput("refill_ready", 32'(wd_ready), 0);

    // Reset on drain beat 4 of the second stored burst.
    for (int e = 0; e <= 4; e++) begin
      applyStimulus(1'b0, 16'h0000, 2'b11, (e == 0), 1'b0);
      exp_d = 16'h4008 + 16'(e);
      checkOutput($sformatf("rstdrain%0d_dq", e), 32'(dq_out), 32'(exp_d));
    end
    rst = 1'b1;
    applyStimulus(1'b0, 16'h0000, 2'b11, 1'b0, 1'b0);
    checkOutput("midrst_oe", 32'(dq_oe), 0);
    checkOutput("midrst_count", 32'(burst_count), 0);
    checkOutput("midrst_dq", 32'(dq_out), 0);
    checkOutput("midrst_dm", 32'(dm_out), 32'h3);
    checkOutput("midrst_ready", 32'(wd_ready), 0);
    rst = 1'b0;
    #1;
    checkOutput("postrst_ready", 32'(wd_ready), 1);
    checkOutput("postrst_avail", 32'(burst_avail), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
